// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: instruction word, opcode encoding and
// the decoded field widths handed to the control unit.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br    = 4'h0,
    op_add   = 4'h1,
    op_ldb   = 4'h2,
    op_stb   = 4'h3,
    op_jsr   = 4'h4,
    op_and   = 4'h5,
    op_ldw   = 4'h6,
    op_stw   = 4'h7,
    op_rti   = 4'h8,
    op_xor   = 4'h9,
    op_rsv_a = 4'hA,
    op_rsv_b = 4'hB,
    op_jmp   = 4'hC,
    op_shf   = 4'hD,
    op_lea   = 4'hE,
    op_trap  = 4'hF
  } lc3b_opcode;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [4:0]  lc3b_imm5;
  typedef logic        lc3b_imm_bit;
  typedef logic [3:0]  lc3b_imm4;
  typedef logic [1:0]  lc3b_shift_flags;
  typedef logic        lc3b_jsr_bit;
  typedef logic [7:0]  lc3b_trapvect8;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;

endpackage

// File: rtl/ir_decode.sv
// Pure field slicer for one LC-3b instruction word; no state.
module ir_decode
  import lc3b_types::*;
(
  input  lc3b_word        word,
  output lc3b_opcode      opcode,
  output lc3b_reg         dest,
  output lc3b_reg         src1,
  output lc3b_reg         src2,
  output lc3b_imm5        imm5,
  output lc3b_imm_bit     imm_bit,
  output lc3b_imm4        imm4,
  output lc3b_shift_flags shift_flags,
  output lc3b_jsr_bit     jsr_bit,
  output lc3b_trapvect8   trapvect8,
  output lc3b_offset6     offset6,
  output lc3b_offset9     offset9,
  output lc3b_offset11    offset11
);

  // All 16 encodings are enumerated, so the cast never yields an illegal value.
  assign opcode      = lc3b_opcode'(word[15:12]);
  assign dest        = word[11:9];
  assign src1        = word[8:6];
  assign src2        = word[2:0];
  assign imm5        = word[4:0];
  assign imm_bit     = word[5];
  assign imm4        = word[3:0];
  assign shift_flags = word[5:4];
  assign jsr_bit     = word[11];
  assign trapvect8   = word[7:0];
  assign offset6     = word[5:0];
  assign offset9     = word[8:0];
  assign offset11    = word[10:0];

endmodule

// File: rtl/ir_queue.sv
// Instruction queue: DEPTH-entry circular buffer with valid/ready on both
// sides, single-cycle flush, and the decoded head entry on the outputs.
module ir_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  lc3b_word                     in,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output lc3b_opcode                   opcode,
  output lc3b_reg                      dest,
  output lc3b_reg                      src1,
  output lc3b_reg                      src2,
  output lc3b_imm5                     imm5,
  output lc3b_imm_bit                  imm_bit,
  output lc3b_imm4                     imm4,
  output lc3b_shift_flags              shift_flags,
  output lc3b_jsr_bit                  jsr_bit,
  output lc3b_trapvect8                trapvect8,
  output lc3b_offset6                  offset6,
  output lc3b_offset9                  offset9,
  output lc3b_offset11                 offset11
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  lc3b_word        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  lc3b_word        head_word;

  // Ready deliberately ignores out_ready: no combinational path across the queue.
  assign in_ready  = (count != FULL) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Empty queue decodes as 16'h0000 so the control unit never sees stale bits.
  assign head_word = out_valid ? mem[rd_ptr] : '0;

  ir_decode u_decode (
    .word        (head_word),
    .opcode      (opcode),
    .dest        (dest),
    .src1        (src1),
    .src2        (src2),
    .imm5        (imm5),
    .imm_bit     (imm_bit),
    .imm4        (imm4),
    .shift_flags (shift_flags),
    .jsr_bit     (jsr_bit),
    .trapvect8   (trapvect8),
    .offset6     (offset6),
    .offset9     (offset9),
    .offset11    (offset11)
  );

endmodule

// File: doc/ir_queue.md
# ir_queue

Parametrised instruction queue that replaces the single-entry instruction register in the LC-3b datapath. It buffers up to DEPTH fetched instruction words under a valid/ready handshake and presents the fully decoded fields of the head (oldest) entry to the control unit and datapath. It also supports a single-cycle flush for branch/trap redirects.

## Interface
- DEPTH, 4, number of instruction entries; power of two, ≥2
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents a word on `in`
- in  in  16 (lc3b_word)  fetched instruction word
- in_ready  out  1  queue accepts a word this cycle
- out_valid  out  1  head entry holds a valid instruction
- out_ready  in  1  consumer retires the head this cycle
- flush  in  1  discard all entries
- count  out  $clog2(DEPTH+1)  number of valid entries
- opcode  out  lc3b_opcode  head[15:12]
- dest  out  lc3b_reg  head[11:9]
- src1  out  lc3b_reg  head[8:6]
- src2  out  lc3b_reg  head[2:0]
- imm5  out  lc3b_imm5  head[4:0]
- imm_bit  out  lc3b_imm_bit  head[5]
- imm4  out  lc3b_imm4  head[3:0]
- shift_flags  out  lc3b_shift_flags  head[5:4]
- jsr_bit  out  lc3b_jsr_bit  head[11]
- trapvect8  out  lc3b_trapvect8  head[7:0]
- offset6  out  lc3b_offset6  head[5:0]
- offset9  out  lc3b_offset9  head[8:0]
- offset11  out  lc3b_offset11  head[10:0]

## Operation
- Storage: circular buffer of DEPTH words, with write pointer wr_ptr, read pointer rd_ptr (each log2(DEPTH) bits, wrapping modulo DEPTH), and count.
- Push happens when in_valid && in_ready: the word is written at wr_ptr, then wr_ptr+1.
- Pop happens when out_valid && out_ready: rd_ptr+1.
- in_ready = (count != DEPTH) && !flush. It does not depend on out_ready, so a full queue with a simultaneous pop still refuses the push.
- out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- out_ready while empty, or in_valid while full: no effect, and no pointer or count change.
- Flush: on the next edge, wr_ptr, rd_ptr and count become 0. Flush overrides any push or pop in the same cycle. Storage contents are not cleared.
- Decoded fields:
  - Purely combinational slices of the head word (storage[rd_ptr]) when out_valid = 1.
  - When out_valid = 0, all fields decode 16'h0000 (opcode = BR, all other fields zero), so the control unit never sees stale bits.
- Reset (reset_n low, asynchronous):
  - Pointers, count and every storage entry go to 0.
  - Outputs: in_ready = 1, out_valid = 0, count = 0, all decoded fields 0.
  - Reset asserted mid-push or mid-pop discards that transfer.

## Timing
- Write-to-head latency is 1 cycle. A word pushed into an empty queue at edge N gives out_valid = 1 and decodes after edge N. There is no same-cycle bypass.
- The pop takes effect at the edge. The next entry's fields are visible after that edge.
- in_ready and out_valid are functions of registered state and flush only. There is no combinational path from in_valid or out_ready.
- Throughput is one push and one pop per cycle sustained while 0 < count < DEPTH.
- After a flush edge: out_valid = 0 and in_ready = 1 in the following cycle.

## Structure
- Shared package lc3b_types holds lc3b_word, lc3b_opcode, lc3b_reg, lc3b_imm5, lc3b_imm_bit, lc3b_imm4, lc3b_shift_flags, lc3b_jsr_bit, lc3b_trapvect8, lc3b_offset6/9/11. Add any missing typedefs there, not locally.
- One combinational sub-module, ir_decode: takes a 16-bit word in and drives all field outputs. ir_queue instantiates it on the head word, gated to zero when empty.
- Queue control (pointers, count, flush priority) stays in ir_queue.

## Test plan
- Reset: hold reset_n low with in_valid = 1 and in = 16'h1234. Then count = 0, out_valid = 0, in_ready = 1, opcode = 0, dest = 0. Release; first push of 16'h1234 gives, one cycle later, opcode = 4'h1, dest = 3'b001, src1 = 3'b000, imm_bit = 1, imm5 = 5'h14.
- Fill/full (DEPTH = 4): push 16'h1001, 16'h2002, 16'h3003, 16'h4004 with out_ready = 0. Then count = 4 and in_ready = 0. A fifth push of 16'h5005 is dropped. Popping 4 times yields 1001, 2002, 3003, 4004 in order, then out_valid = 0.
- Wrap-around: run 10 push/pop pairs with count held at 2. The output order matches the input order across the pointer wrap, and count stays at 2.
- Full + simultaneous pop: count = 4, in_valid = 1, out_ready = 1. One pop occurs, the push is refused, and count = 3.
- Flush priority: count = 2, flush = 1 with in_valid = 1 and out_ready = 1. Next cycle count = 0, out_valid = 0, all fields 0, and the flushed word never appears.
- Decode: head 16'hF025 gives opcode TRAP and trapvect8 = 8'h25. Head 16'h4FFF gives jsr_bit = 1 and offset11 = 11'h7FF. Head 16'hD0A3 gives shift_flags = 2'b10 and imm4 = 4'h3.
